ila_probe_conditioner: RTL and testbench
========================================

// Module: ila_probe_conditioner
// PURPOSE
// Upstream stage of the ila_0 debug core: registers, aligns and conditions robot-car
// debug signals into the nine ILA probe buses. Adds an armable pattern trigger FSM,
// a cycle timestamp, an event pulse stretcher, a saturating event counter and a
// heartbeat, so short or rare events are visible at ILA sample depth.
// Its outputs connect 1:1 to ila_0 probe0..probe8.
// PARAMETERS
// STRETCH   8     cycles probe2 is held high per evt_i rising edge (>=1)
// HOLDOFF   16    cycles after arm during which matches are ignored (0 = none)
// POST_CYC  1024  cycles spent in POST after a trigger (0 = straight to IDLE)
// HB_DIV    50000000  probe8 toggles every HB_DIV cycles (>=1)
// PORTS
// clk          in   1   system clock; sole clock domain
// rst_n        in   1   asynchronous, active-low reset
// dbg_data_i   in   16  debug data word
// dbg_valid_i  in   1   dbg_data_i qualifier
// evt_i        in   1   level event source (same clock domain), rising edges counted
// trig_pattern_i in 16  trigger compare pattern
// trig_mask_i  in   16  compare mask, 1 = bit compared; all-zero = any valid word matches
// arm_i        in   1   arm request, honoured in IDLE only
// disarm_i     in   1   abort to IDLE from any state
// probe0       out  16  dbg_data_i delayed 2 cycles
// probe1       out  1   dbg_valid_i delayed 2 cycles
// probe2       out  1   stretched event
// probe3       out  32  free-running cycle timestamp
// probe4       out  4   FSM state code
// probe5       out  1   trigger pulse, 1 cycle
// probe6       out  1   armed flag
// probe7       out  5   event count since arm, saturating
// probe8       out  1   heartbeat
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, all counters 0. Async assert, sync release use.
// - Data path: stage1 regs data/valid at t; probe0/1 show them at t+2.
// - Match = stage1 valid & (((stage1 data ^ trig_pattern_i) & trig_mask_i) == 0).
// - FSM codes: IDLE=0, HOLD=1, LIVE=2, TRIG=3, POST=4; codes 5-15 unused -> IDLE.
//   IDLE: arm_i -> HOLD (or LIVE if HOLDOFF=0); event count cleared on arm.
//   HOLD: counts HOLDOFF cycles, then LIVE; matches ignored.
//   LIVE: match -> TRIG, so TRIG coincides with the matching word on probe0.
//   TRIG: exactly 1 cycle -> POST (or IDLE if POST_CYC=0).
//   POST: counts POST_CYC cycles -> IDLE. arm_i ignored outside IDLE.
//   disarm_i from any state -> IDLE next cycle; disarm beats arm and match same cycle.
// - probe4 = state reg; probe5 = (state==TRIG); probe6 = state in {HOLD,LIVE}.
// - probe3: +1 every cycle from 0 after reset, wraps 0xFFFFFFFF -> 0, never cleared.
// - probe2: evt_i rising edge (vs. its 1-cycle delayed copy) loads counter = STRETCH;
//   high while counter != 0; new edge while high reloads (retrigger). An isolated edge
//   gives exactly STRETCH high cycles, starting the cycle after the edge is registered.
// - probe7: +1 per evt_i rising edge while state != IDLE; holds at 31; cleared on arm.
// - probe8: divider counts 0..HB_DIV-1, toggles on wrap.
// - Reset mid-operation: everything returns to reset values immediately.
// TESTING
// - Reset release, no stimulus -> probes 0; probe3 = N-1 on Nth post-reset cycle.
// - mask=FFFF pat=A5A5, arm, HOLDOFF=4; A5A5 valid at holdoff cycle 2 -> ignored;
//   A5A5 in LIVE -> probe5 1 cycle with probe0=A5A5, then POST_CYC cycles, IDLE.
// - mask=0000 armed: first valid word triggers; invalid words never trigger.
// - evt_i edges at t and t+3, STRETCH=8 -> probe2 high 11 cycles continuously.
// - 40 evt_i edges while LIVE -> probe7 stops at 31; re-arm -> probe7=0.
// - arm+disarm same cycle -> stays IDLE; disarm in POST -> IDLE next cycle.

Source files
------------

// File: rtl/ila_probe_conditioner_if.sv
// Bus bundle between the debug signal sources, the probe conditioner and the ILA probes.
interface ila_probe_conditioner_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TS_W   = 32;
    localparam int unsigned ST_W   = 4;
    localparam int unsigned ECNT_W = 5;

    logic [DATA_W-1:0] dbg_data_i;
    logic              dbg_valid_i;
    logic              evt_i;
    logic [DATA_W-1:0] trig_pattern_i;
    logic [DATA_W-1:0] trig_mask_i;
    logic              arm_i;
    logic              disarm_i;

    logic [DATA_W-1:0] probe0;
    logic              probe1;
    logic              probe2;
    logic [TS_W-1:0]   probe3;
    logic [ST_W-1:0]   probe4;
    logic              probe5;
    logic              probe6;
    logic [ECNT_W-1:0] probe7;
    logic              probe8;

    // Source side: drives debug signals and trigger controls, observes probes.
    modport master (
        output dbg_data_i, dbg_valid_i, evt_i, trig_pattern_i, trig_mask_i, arm_i, disarm_i,
        input  probe0, probe1, probe2, probe3, probe4, probe5, probe6, probe7, probe8
    );

    // Conditioner side.
    modport slave (
        input  dbg_data_i, dbg_valid_i, evt_i, trig_pattern_i, trig_mask_i, arm_i, disarm_i,
        output probe0, probe1, probe2, probe3, probe4, probe5, probe6, probe7, probe8
    );
endinterface

// File: rtl/ila_probe_conditioner.sv
// Registers and conditions debug signals into the nine ila_0 probe buses: aligned data,
// armable pattern trigger, timestamp, stretched events, saturating event count, heartbeat.
module ila_probe_conditioner #(
    parameter int unsigned STRETCH  = 8,
    parameter int unsigned HOLDOFF  = 16,
    parameter int unsigned POST_CYC = 1024,
    parameter int unsigned HB_DIV   = 50000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ila_probe_conditioner_if.slave  bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TS_W   = 32;
    localparam int unsigned ECNT_W = 5;
    localparam int unsigned STR_W  = (STRETCH < 1) ? 1 : $clog2(STRETCH + 1);
    localparam int unsigned PH_MAX = (HOLDOFF > POST_CYC) ? HOLDOFF : POST_CYC;
    localparam int unsigned PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
    localparam int unsigned HB_W   = (HB_DIV < 2) ? 1 : $clog2(HB_DIV);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_HOLD = 4'd1,
        S_LIVE = 4'd2,
        S_TRIG = 4'd3,
        S_POST = 4'd4
    } state_e;

    state_e              state_q, state_nxt;
    logic [PH_W-1:0]     ph_q, ph_nxt;
    logic                arm_hit_c;
    logic                match_c;
    logic                trig_nxt_c, armed_nxt_c;
    logic                trig_q, armed_q;

    logic [DATA_W-1:0]   s1_data_q, p0_q;
    logic                s1_valid_q, p1_q;

    logic                evt_d_q, rise_c;
    logic [STR_W-1:0]    str_q, str_nxt;
    logic                str_on_q;
    logic [ECNT_W-1:0]   ecnt_q;

    logic [TS_W-1:0]     ts_q;
    logic [HB_W-1:0]     hb_q;
    logic                hb_tgl_q;

    // Two-stage alignment of the debug word so probe0 lines up with the trigger pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            p0_q       <= '0;
            p1_q       <= 1'b0;
        end else begin
            s1_data_q  <= bus.dbg_data_i;
            s1_valid_q <= bus.dbg_valid_i;
            p0_q       <= s1_data_q;
            p1_q       <= s1_valid_q;
        end
    end

    // Masked pattern compare on the first stage; an all-zero mask matches any valid word.
    always_comb begin
        match_c = s1_valid_q & (((s1_data_q ^ bus.trig_pattern_i) & bus.trig_mask_i) == '0);
    end

    // Trigger state register, phase counter and registered state decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            trig_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ph_q    <= ph_nxt;
            trig_q  <= trig_nxt_c;
            armed_q <= armed_nxt_c;
        end
    end

    // Next-state logic; disarm overrides arm and match.
    always_comb begin
        state_nxt = state_q;
        ph_nxt    = ph_q;
        arm_hit_c = 1'b0;
        if (bus.disarm_i) begin
            state_nxt = S_IDLE;
            ph_nxt    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.arm_i) begin
                        arm_hit_c = 1'b1;
                        ph_nxt    = '0;
                        state_nxt = (HOLDOFF == 0) ? S_LIVE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ph_q == PH_W'(HOLDOFF - 1)) begin
                        state_nxt = S_LIVE;
                        ph_nxt    = '0;
                    end else begin
                        ph_nxt = ph_q + PH_W'(1);
                    end
                end
                S_LIVE: begin
                    if (match_c) begin
                        state_nxt = S_TRIG;
                    end
                end
                S_TRIG: begin
                    ph_nxt    = '0;
                    state_nxt = (POST_CYC == 0) ? S_IDLE : S_POST;
                end
                S_POST: begin
                    if (ph_q == PH_W'(POST_CYC - 1)) begin
                        state_nxt = S_IDLE;
                        ph_nxt    = '0;
                    end else begin
                        ph_nxt = ph_q + PH_W'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    ph_nxt    = '0;
                end
            endcase
        end
    end

    // Output decodes of the upcoming state, registered alongside it.
    always_comb begin
        trig_nxt_c  = (state_nxt == S_TRIG);
        armed_nxt_c = (state_nxt == S_HOLD) || (state_nxt == S_LIVE);
    end

    // Rising-edge detect and retriggerable stretch countdown.
    always_comb begin
        rise_c  = bus.evt_i & ~evt_d_q;
        str_nxt = str_q;
        if (rise_c) begin
            str_nxt = STR_W'(STRETCH);
        end else if (str_q != '0) begin
            str_nxt = str_q - STR_W'(1);
        end
    end

    // Event stretcher and saturating event counter, cleared when an arm is honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_d_q  <= 1'b0;
            str_q    <= '0;
            str_on_q <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            evt_d_q  <= bus.evt_i;
            str_q    <= str_nxt;
            str_on_q <= (str_nxt != '0);
            if (arm_hit_c) begin
                ecnt_q <= '0;
            end else if (rise_c && (state_q != S_IDLE) && (ecnt_q != '1)) begin
                ecnt_q <= ecnt_q + ECNT_W'(1);
            end
        end
    end

    // Free-running timestamp and heartbeat divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            hb_q     <= '0;
            hb_tgl_q <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (hb_q == HB_W'(HB_DIV - 1)) begin
                hb_q     <= '0;
                hb_tgl_q <= ~hb_tgl_q;
            end else begin
                hb_q <= hb_q + HB_W'(1);
            end
        end
    end

    assign bus.probe0 = p0_q;
    assign bus.probe1 = p1_q;
    assign bus.probe2 = str_on_q;
    assign bus.probe3 = ts_q;
    assign bus.probe4 = state_q;
    assign bus.probe5 = trig_q;
    assign bus.probe6 = armed_q;
    assign bus.probe7 = ecnt_q;
    assign bus.probe8 = hb_tgl_q;
endmodule

// File: tb/tb_ila_probe_conditioner.sv
// Scoreboard bench for ila_probe_conditioner: stimulus pushes per-cycle expected probes
// from a cycle-indexed reference model; a monitor pops and compares after each edge.
module tb_ila_probe_conditioner;
    localparam int unsigned STRETCH  = 8;
    localparam int unsigned HOLDOFF  = 4;
    localparam int unsigned POST_CYC = 6;
    localparam int unsigned HB_DIV   = 5;

    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_LIVE = 2;
    localparam int M_TRIG = 3;
    localparam int M_POST = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ila_probe_conditioner_if bus_if ();

    ila_probe_conditioner #(
        .STRETCH (STRETCH),
        .HOLDOFF (HOLDOFF),
        .POST_CYC(POST_CYC),
        .HB_DIV  (HB_DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    typedef struct packed {
        logic [15:0] p0;
        logic        p1;
        logic        p2;
        logic [31:0] p3;
        logic [3:0]  p4;
        logic        p5;
        logic        p6;
        logic [4:0]  p7;
        logic        p8;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state, indexed by clock edges since reset release.
    int          k;
    logic [15:0] prev_d;
    logic        prev_v;
    logic        prev_e;
    int          mode;
    int          rem;
    int          cnt;
    int          last_rise;
    bit          have_rise;
    logic [15:0] cur_pat;
    logic [15:0] cur_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        k         = 0;
        prev_d    = '0;
        prev_v    = 1'b0;
        prev_e    = 1'b0;
        mode      = M_IDLE;
        rem       = 0;
        cnt       = 0;
        last_rise = 0;
        have_rise = 0;
    endtask

    // Drive one cycle of inputs (applied at the next rising edge) and queue the expectation.
    task automatic cyc(input logic [15:0] d, input logic v, input logic e,
                       input logic arm, input logic dis);
        exp_t x;
        bit   rise;
        bit   match;
        bit   arm_ok;
        int   old;
        bus_if.dbg_data_i     = d;
        bus_if.dbg_valid_i    = v;
        bus_if.evt_i          = e;
        bus_if.trig_pattern_i = cur_pat;
        bus_if.trig_mask_i    = cur_mask;
        bus_if.arm_i          = arm;
        bus_if.disarm_i       = dis;

        k++;
        rise   = e && !prev_e;
        match  = prev_v && (((prev_d ^ cur_pat) & cur_mask) == 16'h0000);
        old    = mode;
        arm_ok = 0;
        if (dis) begin
            mode = M_IDLE;
        end else if (old == M_IDLE) begin
            if (arm) begin
                arm_ok = 1;
                if (HOLDOFF == 0) mode = M_LIVE;
                else begin mode = M_HOLD; rem = int'(HOLDOFF); end
            end
        end else if (old == M_HOLD) begin
            rem--;
            if (rem == 0) mode = M_LIVE;
        end else if (old == M_LIVE) begin
            if (match) mode = M_TRIG;
        end else if (old == M_TRIG) begin
            if (POST_CYC == 0) mode = M_IDLE;
            else begin mode = M_POST; rem = int'(POST_CYC); end
        end else begin
            rem--;
            if (rem == 0) mode = M_IDLE;
        end
        if (arm_ok) cnt = 0;
        else if (rise && old != M_IDLE && cnt < 31) cnt++;
        if (rise) begin
            last_rise = k;
            have_rise = 1;
        end

        x.p0 = prev_d;
        x.p1 = prev_v;
        x.p2 = have_rise && ((k - last_rise) < int'(STRETCH));
        x.p3 = 32'(k);
        x.p4 = 4'(mode);
        x.p5 = (mode == M_TRIG);
        x.p6 = (mode == M_HOLD) || (mode == M_LIVE);
        x.p7 = 5'(cnt);
        x.p8 = 1'((k / int'(HB_DIV)) % 2);
        exp_q.push_back(x);

        prev_d = d;
        prev_v = v;
        prev_e = e;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rst_check();
        chk("rst_probe0", 32'(bus_if.probe0), 32'h0);
        chk("rst_probe1", 32'(bus_if.probe1), 32'h0);
        chk("rst_probe2", 32'(bus_if.probe2), 32'h0);
        chk("rst_probe3", bus_if.probe3, 32'h0);
        chk("rst_probe4", 32'(bus_if.probe4), 32'h0);
        chk("rst_probe5", 32'(bus_if.probe5), 32'h0);
        chk("rst_probe6", 32'(bus_if.probe6), 32'h0);
        chk("rst_probe7", 32'(bus_if.probe7), 32'h0);
        chk("rst_probe8", 32'(bus_if.probe8), 32'h0);
    endtask

    // Assert reset mid-run (at a falling edge), check outputs cleared, then release.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_check();
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: compare the DUT probes against the queued expectation after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("probe0_data",   32'(bus_if.probe0), 32'(e.p0));
            chk("probe1_valid",  32'(bus_if.probe1), 32'(e.p1));
            chk("probe2_stretch", 32'(bus_if.probe2), 32'(e.p2));
            chk("probe3_tstamp", bus_if.probe3, e.p3);
            chk("probe4_state",  32'(bus_if.probe4), 32'(e.p4));
            chk("probe5_trig",   32'(bus_if.probe5), 32'(e.p5));
            chk("probe6_armed",  32'(bus_if.probe6), 32'(e.p6));
            chk("probe7_evtcnt", 32'(bus_if.probe7), 32'(e.p7));
            chk("probe8_hbeat",  32'(bus_if.probe8), 32'(e.p8));
        end
    end

    initial begin
        logic [15:0] d;
        bus_if.dbg_data_i     = '0;
        bus_if.dbg_valid_i    = 1'b0;
        bus_if.evt_i          = 1'b0;
        bus_if.trig_pattern_i = '0;
        bus_if.trig_mask_i    = '0;
        bus_if.arm_i          = 1'b0;
        bus_if.disarm_i       = 1'b0;
        cur_pat  = 16'h0000;
        cur_mask = 16'h0000;
        model_reset();

        // Reset state and idle timestamp run-up.
        #12;
        rst_check();
        @(negedge clk);
        rst_n = 1'b1;
        idle(7);

        // Exact pattern: match during holdoff ignored, match in LIVE triggers then POST.
        cur_pat  = 16'hA5A5;
        cur_mask = 16'hFFFF;
        cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        cyc(16'hA5A4, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(POST_CYC + 4);

        // Zero mask: invalid words never trigger, first valid word does.
        cur_mask = 16'h0000;
        cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(16'h1357, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(POST_CYC + 4);

        // Two evt edges three cycles apart: one continuous stretched pulse.
        cyc(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(14);

        // Saturation of the event counter, then re-arm clears it.
        cur_pat  = 16'hFFFF;
        cur_mask = 16'hFFFF;
        cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Arm and disarm together stays idle; disarm during POST returns to idle.
        cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        cur_mask = 16'h0000;
        cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        cyc(16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Reset in the middle of an armed run with pending events.
        cur_mask = 16'hFFFF;
        cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ((i % 40) == 0) begin
                cur_pat = 16'($urandom);
                case ($urandom_range(0, 2))
                    0: cur_mask = 16'hFFFF;
                    1: cur_mask = 16'h0000;
                    default: cur_mask = 16'($urandom);
                endcase
            end
            d = ($urandom_range(0, 7) == 0) ? cur_pat : 16'($urandom);
            cyc(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 59) == 0));
        end
        idle(2);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
